reg_wb_queue: RTL
=================

Name: reg_wb_queue

Overview:
- Write-side front end for the 8x8 dual-read/single-write register file: collects writeback results from the ALU and load unit, buffers them in order, and drives the reg file write port at most once per cycle.
- The reg file freezes its read outputs during a write cycle. This block therefore yields the write port when decode asserts i_hold.
- It also forwards pending (not yet written) results to decode so operand reads stay coherent.

Parameters:
- DEPTH, 4, queue entries (power of 2, >=2)
- ADDR_W, 3, register address width
- DATA_W, 8, register data width

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_alu_valid  in  1  ALU result valid
- i_alu_addr  in  ADDR_W  ALU destination register
- i_alu_data  in  DATA_W  ALU result
- o_alu_ready  out  1  ALU result accepted when valid&ready at edge
- i_ld_valid  in  1  load result valid
- i_ld_addr  in  ADDR_W  load destination register
- i_ld_data  in  DATA_W  load data
- o_ld_ready  out  1  load accepted when valid&ready at edge
- i_hold  in  1  decode needs reg file read port; suppress drain
- o_write  out  1  reg file write enable (registered)
- o_w_address  out  ADDR_W  reg file write address (registered)
- o_w_data  out  DATA_W  reg file write data (registered)
- i_r_address1, i_r_address2  in  ADDR_W  decode operand addresses
- o_fwd_hit1, o_fwd_hit2  out  1  pending write exists for address (comb)
- o_fwd_data1, o_fwd_data2  out  DATA_W  youngest pending data (comb)
- o_count  out  $clog2(DEPTH)+1  occupied entries
- o_empty  out  1  count==0 and o_write==0

Behaviour:
- Reset (async, i_rst_n low): queue cleared; count=0; o_write=0; o_w_address=0; o_w_data=0. Reset mid-operation drops all pending entries, including the in-flight write.
- Free = DEPTH - count, sampled before this cycle's pop.
- o_alu_ready = free>=1.
- o_ld_ready = free>=2, or (free>=1 and !i_alu_valid).
- Same-cycle ALU and load acceptance: ALU is enqueued first (older), load second.
- Drain: at each edge with count>0 and !i_hold, pop the head into o_w_address/o_w_data and set o_write=1 for the following cycle. Otherwise o_write=0 and the address/data registers hold their values.
- Push and pop in the same edge are allowed. A full queue that pops this edge does NOT raise ready in the same cycle (no drain credit).
- Latency: acceptance at edge k into an empty queue -> o_write high in the cycle after edge k+1. No bypass from input to output.
- i_hold high: o_write is 0 in the next cycle. Entries are retained; accepts continue while space remains.
- Forwarding, combinational per read port:
  - Search queue entries youngest-to-oldest, then the output register when o_write=1.
  - The first address match gives hit=1 and that entry's data; no match gives hit=0, data=0.
  - Multiple pending writes to one address: the youngest wins.
- Count range 0..DEPTH. Pointers wrap mod DEPTH. Overflow is impossible by construction; the verifier asserts count<=DEPTH.

Optional Feature:
- Macro REG_WB_R0_DISCARD_EN.
- Defined: register 0 is hardwired zero.
  - Requests with addr==0 are handshaked (ready as normal) but not enqueued.
  - Forwarding on address 0 returns hit=0.
- Undefined: address 0 is an ordinary register.

Decomposition:
- Package omega8_pkg:
  - REG_ADDR_W=3, REG_DATA_W=8
  - typedef wb_entry_t {addr, data}
- Sub-module wb_fifo: generic synchronous FIFO of wb_entry_t, with dual push (ordered), single pop, and entry-visible outputs for the forwarding search.
- Forwarding priority mux and ready logic stay in reg_wb_queue.

Test Plan:
- Reset then ALU push (r3, 0x5A) at edge k -> o_write=1, o_w_address=3, o_w_data=0x5A in cycle after k+1; o_empty=1 after.
- Simultaneous ALU (r1, 0x11) and load (r2, 0x22) into an empty queue -> both accepted; writes issue r1 then r2 on consecutive cycles.
- Fill 4 entries with i_hold=1 -> o_alu_ready=0, o_write stays 0. Release hold -> 4 back-to-back writes in FIFO order.
- Pending writes r5=0x10 then r5=0x20; i_r_address1=5 -> o_fwd_hit1=1, o_fwd_data1=0x20. After both drain -> hit1=0.
- Assert i_rst_n=0 asynchronously with 3 entries queued and o_write=1 -> o_write=0 immediately, count=0, no further writes.
- With REG_WB_R0_DISCARD_EN: ALU push (r0, 0xFF) -> ready=1, count stays 0, no o_write, fwd hit for r0 = 0.

Source files
------------

// File: rtl/omega8_pkg.sv
// Shared register-file widths and the writeback entry type for the omega8 core.
package omega8_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_wb_fifo.sv
// In-order writeback FIFO: two ordered pushes and one pop per cycle, with the raw
// storage and read pointer exposed so the owner can search pending entries.
module wb_fifo
  import omega8_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push0_i,
  input  wb_entry_t       push0_data_i,
  input  logic            push1_i,
  input  wb_entry_t       push1_data_i,
  input  logic            pop_i,
  output wb_entry_t       head_o,
  output logic [CW-1:0]   count_o,
  output logic [PW-1:0]   rd_ptr_o,
  output wb_entry_t       entries_o [DEPTH]
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] slot1;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t     mem_q [DEPTH];

  // A lone push1 takes the tail slot; when both push, push0 is the older entry.
  always_comb begin
    slot1    = push0_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push0_i) begin
        mem_q[wr_ptr_q] <= push0_data_i;
      end
      if (push1_i) begin
        mem_q[slot1] <= push1_data_i;
      end
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the 8x8 register file: merges ALU/load results, drains one
// per cycle unless decode holds, and forwards pending data. Option: REG_WB_R0_DISCARD_EN.
module reg_wb_queue
  import omega8_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_addr,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_alu_ready,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  input  logic              i_hold,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_w_address,
  output logic [DATA_W-1:0] o_w_data,
  input  logic [ADDR_W-1:0] i_r_address1,
  input  logic [ADDR_W-1:0] i_r_address2,
  output logic              o_fwd_hit1,
  output logic              o_fwd_hit2,
  output logic [DATA_W-1:0] o_fwd_data1,
  output logic [DATA_W-1:0] o_fwd_data2,
  output logic [CW-1:0]     o_count,
  output logic              o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic [PW-1:0]     rd_ptr;
  wb_entry_t         head;
  wb_entry_t         entries [DEPTH];
  wb_entry_t         alu_entry, ld_entry;
  logic              alu_keep, ld_keep;
  logic              push0, push1, pop;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr [2];
  logic              hit   [2];
  logic [DATA_W-1:0] fdata [2];

  // Credit is taken from the pre-pop count, so a draining full queue stays not-ready.
  assign free        = CW'(DEPTH) - count;
  assign o_alu_ready = (free >= CW'(1));
  assign o_ld_ready  = (free >= CW'(2)) || ((free >= CW'(1)) && !i_alu_valid);

`ifdef REG_WB_R0_DISCARD_EN
  assign alu_keep = (i_alu_addr != '0);
  assign ld_keep  = (i_ld_addr != '0);
`else
  assign alu_keep = 1'b1;
  assign ld_keep  = 1'b1;
`endif

  assign alu_entry = '{addr: i_alu_addr, data: i_alu_data};
  assign ld_entry  = '{addr: i_ld_addr, data: i_ld_data};
  assign push0     = i_alu_valid && o_alu_ready && alu_keep;
  assign push1     = i_ld_valid && o_ld_ready && ld_keep;
  assign pop       = (count != '0) && !i_hold;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .push0_i      (push0),
    .push0_data_i (alu_entry),
    .push1_i      (push1),
    .push1_data_i (ld_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .rd_ptr_o     (rd_ptr),
    .entries_o    (entries)
  );

  always_comb begin
    write_d = pop;
    waddr_d = pop ? head.addr : waddr_q;
    wdata_d = pop ? head.data : wdata_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign raddr[0] = i_r_address1;
  assign raddr[1] = i_r_address2;

  // Scan oldest to youngest so later matches overwrite; the output register is oldest of all.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit[p]   = 1'b0;
      fdata[p] = '0;
      if (write_q && (waddr_q == raddr[p])) begin
        hit[p]   = 1'b1;
        fdata[p] = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count) && (entries[rd_ptr + PW'(i)].addr == raddr[p])) begin
          hit[p]   = 1'b1;
          fdata[p] = entries[rd_ptr + PW'(i)].data;
        end
      end
`ifdef REG_WB_R0_DISCARD_EN
      if (raddr[p] == '0) begin
        hit[p]   = 1'b0;
        fdata[p] = '0;
      end
`endif
    end
  end

  assign o_write     = write_q;
  assign o_w_address = waddr_q;
  assign o_w_data    = wdata_q;
  assign o_fwd_hit1  = hit[0];
  assign o_fwd_hit2  = hit[1];
  assign o_fwd_data1 = fdata[0];
  assign o_fwd_data2 = fdata[1];
  assign o_count     = count;
  assign o_empty     = (count == '0) && !write_q;

endmodule
